// File: rtl/dso_trig_capture_ram_if.sv
// Sample-stream and read-port bundle for the DSO trigger capture buffer.
// master drives samples/trigger/read requests; slave returns read data.
interface dso_trig_capture_ram_if #(
    parameter int CH_NUM     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                           smp_valid;
    logic [CH_NUM*DATA_WIDTH-1:0]   smp_data;
    logic                           trig;
    logic                           rd_en;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic [CH_NUM*DATA_WIDTH-1:0]   rd_data;
    logic                           rd_valid;

    modport master (
        output smp_valid, smp_data, trig, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  smp_valid, smp_data, trig, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/dso_trig_capture_ram.sv
// Pre/post-trigger circular capture RAM for a multi-channel DSO front end.
// Ports: wr_clk, tb_wr_rst (async, active-high), arm/abort/pre_trig_len
// control, busy/done/trig_addr status, sample + read bundle via bus.
module dso_trig_capture_ram #(
    parameter int CH_NUM     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int OUTPUT_REG = 0
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pre_trig_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    dso_trig_capture_ram_if.slave bus
);
    localparam int W     = CH_NUM * DATA_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] pre_len;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [W-1:0]          mem [DEPTH];

    logic                  arm_ok;
    logic                  wr_en;
    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] rd_phys;
    logic                  rd_v1;
    logic [W-1:0]          rd_q;

    assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign done = (state == S_DONE);

    assign arm_ok = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
    assign wr_en  = busy && bus.smp_valid && !abort;

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            pre_len   <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else if (arm_ok) begin
            wr_ptr   <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            pre_len  <= pre_trig_len;
            state    <= (pre_trig_len == '0) ? S_WAIT : S_PRE;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            case (state)
                S_PRE: begin
                    pre_cnt <= pre_cnt + 1'b1;
                    if (pre_cnt + 1'b1 == pre_len)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.trig) begin
                        trig_addr <= wr_ptr;
                        // DEPTH-1-pre_len is the bitwise inverse in AW bits
                        post_cnt  <= ~pre_len;
                        state     <= (pre_len == '1) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == ADDR_WIDTH'(1))
                        state <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset: captured data survives reset for post-mortem reads
    always_ff @(posedge wr_clk) begin
        if (wr_en)
            mem[wr_ptr] <= bus.smp_data;
    end

    // Logical index 0 maps to the oldest kept sample, pre_len before trigger
    assign rd_ok   = bus.rd_en && done;
    assign rd_phys = trig_addr - pre_len + bus.rd_addr;

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            rd_v1 <= 1'b0;
            rd_q  <= '0;
        end else begin
            rd_v1 <= rd_ok;
            if (rd_ok)
                rd_q <= mem[rd_phys];
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic         rd_v2;
            logic [W-1:0] rd_q2;

            always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
                if (tb_wr_rst) begin
                    rd_v2 <= 1'b0;
                    rd_q2 <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1)
                        rd_q2 <= rd_q;
                end
            end

            assign bus.rd_valid = rd_v2;
            assign bus.rd_data  = rd_q2;
        end else begin : g_noreg
            assign bus.rd_valid = rd_v1;
            assign bus.rd_data  = rd_q;
        end
    endgenerate
endmodule

// File: tb/tb_dso_trig_capture_ram.sv
// Directed bench for dso_trig_capture_ram: runs an OUTPUT_REG=0 and an
// OUTPUT_REG=1 instance side by side on identical stimulus.
module tb_dso_trig_capture_ram;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          abort;
    logic [AW-1:0] pre_trig_len;
    logic          smp_valid;
    logic [15:0]   smp_data;
    logic          trig;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic          busy0, done0, busy1, done1;
    logic [AW-1:0] trig_addr0, trig_addr1;

    int n_chk  = 0;
    int n_fail = 0;

    dso_trig_capture_ram_if #(.CH_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(AW)) bus0 ();
    dso_trig_capture_ram_if #(.CH_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.smp_valid = smp_valid;
    assign bus0.smp_data  = smp_data;
    assign bus0.trig      = trig;
    assign bus0.rd_en     = rd_en;
    assign bus0.rd_addr   = rd_addr;
    assign bus1.smp_valid = smp_valid;
    assign bus1.smp_data  = smp_data;
    assign bus1.trig      = trig;
    assign bus1.rd_en     = rd_en;
    assign bus1.rd_addr   = rd_addr;

    dso_trig_capture_ram #(.OUTPUT_REG(0)) u_dut0 (
        .wr_clk       (clk),
        .tb_wr_rst    (rst),
        .arm          (arm),
        .abort        (abort),
        .pre_trig_len (pre_trig_len),
        .busy         (busy0),
        .done         (done0),
        .trig_addr    (trig_addr0),
        .bus          (bus0)
    );

    dso_trig_capture_ram #(.OUTPUT_REG(1)) u_dut1 (
        .wr_clk       (clk),
        .tb_wr_rst    (rst),
        .arm          (arm),
        .abort        (abort),
        .pre_trig_len (pre_trig_len),
        .busy         (busy1),
        .done         (done1),
        .trig_addr    (trig_addr1),
        .bus          (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample i: ch0 = i+salt, ch1 = ch0+0x80 (8-bit wrap)
    function automatic logic [15:0] dat(input int i, input logic [7:0] salt);
        logic [7:0] b;
        b = 8'(i) + salt;
        return {b + 8'h80, b};
    endfunction

    task automatic do_arm(input int pre);
        arm          = 1'b1;
        pre_trig_len = AW'(pre);
        step();
        arm = 1'b0;
    endtask

    task automatic send(input int i, input logic [7:0] salt, input logic t);
        smp_valid = 1'b1;
        smp_data  = dat(i, salt);
        trig      = t;
        step();
        smp_valid = 1'b0;
        trig      = 1'b0;
    endtask

    // Arm, stream a ramp with one trigger; done lands trig+DEPTH-1-pre later
    task automatic capture(input string tag, input int pre, input int tidx,
                           input logic [7:0] salt);
        int n;
        n = tidx + DEPTH - pre;
        do_arm(pre);
        check({tag, "_busy"}, busy0, 1);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)
                check({tag, "_early_done"}, done0, 0);
            send(i, salt, i == tidx);
        end
        check({tag, "_done0"}, done0, 1);
        check({tag, "_done1"}, done1, 1);
        check({tag, "_idle"}, busy0, 0);
        check({tag, "_taddr"}, trig_addr0, tidx % DEPTH);
    endtask

    task automatic do_read(input string tag, input int a, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step();
        rd_en = 1'b0;
        check({tag, "_v0"}, bus0.rd_valid, 1);
        check({tag, "_d0"}, bus0.rd_data, exp);
        check({tag, "_v1early"}, bus1.rd_valid, 0);
        step();
        check({tag, "_v0off"}, bus0.rd_valid, 0);
        check({tag, "_d0hold"}, bus0.rd_data, exp);
        check({tag, "_v1"}, bus1.rd_valid, 1);
        check({tag, "_d1"}, bus1.rd_data, exp);
    endtask

    initial begin
        rst = 1'b1;
        arm = 1'b0; abort = 1'b0; pre_trig_len = '0;
        smp_valid = 1'b0; smp_data = '0; trig = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        step();
        step();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_taddr", trig_addr0, 0);
        check("rst_rdv", bus0.rd_valid, 0);
        check("rst_rdd", bus1.rd_data, 0);
        rst = 1'b0;
        step();

        // Ramp capture, pre 100, trig on sample 500
        capture("c1", 100, 500, 8'h00);
        rd_en = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            step();
            check("p_v0", bus0.rd_valid, 1);
            check("p_d0", bus0.rd_data, dat(400 + k, 8'h00));
            if (k > 0) begin
                check("p_v1", bus1.rd_valid, 1);
                check("p_d1", bus1.rd_data, dat(399 + k, 8'h00));
            end else begin
                check("p_v1first", bus1.rd_valid, 0);
            end
        end
        rd_en = 1'b0;
        step();
        check("p_v0end", bus0.rd_valid, 0);
        check("p_d0hold", bus0.rd_data, dat(1423, 8'h00));
        check("p_v1last", bus1.rd_valid, 1);
        check("p_d1last", bus1.rd_data, dat(1423, 8'h00));
        step();
        check("p_v1end", bus1.rd_valid, 0);

        // Zero pre-trigger, trigger on first sample
        capture("c2", 0, 0, 8'h55);
        do_read("c2r0", 0, dat(0, 8'h55));
        do_read("c2r1", 1, dat(1, 8'h55));
        do_read("c2r1023", 1023, dat(1023, 8'h55));

        // Maximum pre-trigger, trigger after wrap at address 5
        capture("c3", 1023, 1029, 8'h11);
        do_read("c3trig", 1023, dat(1029, 8'h11));
        do_read("c3old", 0, dat(6, 8'h11));

        // Unqualified triggers ignored, then abort+arm in POST
        do_arm(4);
        send(0, 8'h33, 1'b0);
        send(1, 8'h33, 1'b1);
        send(2, 8'h33, 1'b0);
        send(3, 8'h33, 1'b0);
        trig = 1'b1;
        step();
        trig = 1'b0;
        check("t4_busy", busy0, 1);
        check("t4_done", done0, 0);
        send(4, 8'h33, 1'b0);
        check("t4_wait", done0, 0);
        send(5, 8'h33, 1'b1);
        check("t4_taddr", trig_addr0, 5);
        check("t4_post", busy0, 1);
        abort = 1'b1;
        arm   = 1'b1;
        pre_trig_len = AW'(0);
        step();
        abort = 1'b0;
        arm   = 1'b0;
        check("ab_busy", busy0, 0);
        check("ab_done", done0, 0);
        check("ab_busy1", busy1, 0);
        rd_en   = 1'b1;
        rd_addr = '0;
        step();
        rd_en = 1'b0;
        check("ab_rdv0", bus0.rd_valid, 0);
        check("ab_busy_hold", busy0, 0);
        step();
        check("ab_rdv1", bus1.rd_valid, 0);

        // Async reset while waiting for trigger
        do_arm(2);
        send(0, 8'h44, 1'b0);
        send(1, 8'h44, 1'b0);
        check("r_wait", busy1, 1);
        #2;
        rst = 1'b1;
        #1;
        check("r_busy", busy1, 0);
        check("r_done", done1, 0);
        check("r_taddr", trig_addr1, 0);
        check("r_rdv", bus1.rd_valid, 0);
        check("r_rdd", bus1.rd_data, 0);
        check("r_taddr0", trig_addr0, 0);
        step();
        rst = 1'b0;
        send(2, 8'h44, 1'b1);
        check("r_noarm", busy1, 0);

        capture("c6", 3, 5, 8'h22);
        do_read("c6old", 0, dat(2, 8'h22));
        do_read("c6trig", 3, dat(5, 8'h22));
        do_read("c6wrap0", 1022, dat(1024, 8'h22));
        do_read("c6last", 1023, dat(1025, 8'h22));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
